// File: rtl/pixel_arb_pkg.sv
// pixel_arb_pkg: shared owner states, requester ids and pixel bus widths for the VGA write path
package pixel_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_e;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 3;
endpackage

// File: rtl/pixel_wr_arbiter_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones, with clear taking priority
module sat_counter16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 16'd0 : (inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  end
  assign q = cnt_q;
endmodule

// File: rtl/pixel_wr_arbiter.sv
// pixel_wr_arbiter: round-robin, burst-bounded sharing of the pixel buffer write port between two writers
module pixel_wr_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              cnt_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  owner_e state_q, state_d;
  logic last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic mem_we_q, mem_we_d, busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic win_a, win_b;
  // The owner keeps the port until its burst is spent while the other side waits.
  always_comb begin
    win_a = reset_n && a_req && (state_q == OWN_A ? (burst_q != MB || !b_req)
                               : state_q == OWN_B ? !(b_req && burst_q != MB)
                               : (!b_req || last_q == REQ_B));
    win_b = reset_n && b_req && (state_q == OWN_B ? (burst_q != MB || !a_req)
                               : state_q == OWN_A ? !(a_req && burst_q != MB)
                               : (!a_req || last_q == REQ_A));
    state_d = win_a ? OWN_A : win_b ? OWN_B : IDLE;
    last_d = win_a ? REQ_A : win_b ? REQ_B : last_q;
    burst_d = !(win_a || win_b) ? 4'd0
            : state_d == state_q ? (burst_q == MB ? MB : burst_q + 4'd1)
            : 4'd1;
    mem_we_d = win_a || win_b;
    mem_addr_d = win_a ? a_addr : win_b ? b_addr : mem_addr_q;
    mem_data_d = win_a ? a_data : win_b ? b_data : mem_data_q;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= REQ_B;
      burst_q <= 4'd0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      burst_q <= burst_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q <= busy_d;
    end
  end
  sat_counter16 u_conflict (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .inc    (a_req && b_req),
    .q      (conflict_cnt)
  );
  assign a_ack = win_a;
  assign b_ack = win_b;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_pixel_wr_arbiter.sv
// tb_pixel_wr_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_pixel_wr_arbiter;
  localparam int AW = 15, DW = 3, MB = 4;
  logic clk = 0, reset_n, a_req, b_req, a_ack, b_ack, cnt_clr, mem_we, busy;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_data, b_data, mem_data;
  logic [15:0] conflict_cnt;
  int n_chk = 0, n_fail = 0;
  bit en = 0;
  always #5 clk = ~clk;
  pixel_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .cnt_clr(cnt_clr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: who owns the port (0 none, 1 A, 2 B), who was served last, length of the current run.
  int m_owner, m_last, m_run, m_cnt;
  bit m_we, m_busy;
  int m_addr, m_data;
  function automatic int exp_win();
    if (!reset_n || (!a_req && !b_req)) return 0;
    if (a_req && !b_req) return 1;
    if (b_req && !a_req) return 2;
    if (m_owner == 0) return m_last == 1 ? 2 : 1;
    return m_run < MB ? m_owner : 3 - m_owner;
  endfunction
  always @(posedge clk) begin
    int w;
    w = exp_win();
    if (!reset_n) begin
      m_owner = 0; m_last = 2; m_run = 0; m_cnt = 0;
      m_we = 0; m_busy = 0; m_addr = 0; m_data = 0;
    end else begin
      if (w != 0) begin
        m_run = (w == m_owner) ? (m_run < MB ? m_run + 1 : MB) : 1;
        m_owner = w; m_last = w; m_we = 1;
        m_addr = w == 1 ? int'(a_addr) : int'(b_addr);
        m_data = w == 1 ? int'(a_data) : int'(b_data);
      end else begin
        m_owner = 0; m_run = 0; m_we = 0;
      end
      m_busy = w != 0;
      m_cnt = cnt_clr ? 0 : (a_req && b_req && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end
  end
  always @(negedge clk) if (en) begin
    int w;
    w = exp_win();
    chk("a_ack", a_ack, w == 1);
    chk("b_ack", b_ack, w == 2);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data", mem_data, m_data);
    chk("busy", busy, m_busy);
    chk("conflict_cnt", conflict_cnt, m_cnt);
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, got;
    bit aa, bb;
    reset_n = 0; a_req = 0; b_req = 0; cnt_clr = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
    repeat (2) nxt();
    en = 1;
    reset_n = 1; a_req = 1; a_addr = 15'h0005; a_data = 3'b101;
    @(negedge clk); chk("t1_a_ack", a_ack, 1); chk("t1_b_ack", b_ack, 0);
    nxt(); a_req = 0;
    @(negedge clk); chk("t1_we", mem_we, 1); chk("t1_addr", mem_addr, 5);
    chk("t1_data", mem_data, 5); chk("t1_b_ack2", b_ack, 0);
    reset_n = 0; nxt();
    reset_n = 1; a_req = 1; b_req = 1; a_addr = 1; b_addr = 2;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t2_ack", {a_ack, b_ack}, (i < 4 || i == 8) ? 2'b10 : 2'b01);
      chk("t2_we", mem_we, i > 0);
      chk("t2_cnt", conflict_cnt, i);
      nxt();
    end
    b_req = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); n += int'(a_ack);
      nxt(); a_addr = a_addr + 1;
    end
    chk("t3_burst", n, 10);
    chk("t3_cnt", conflict_cnt, 9);
    b_req = 1; got = 0;
    for (int i = 0; i < 5 && got == 0; i++) begin
      @(negedge clk); got = int'(b_ack);
      nxt(); a_addr = a_addr + 1;
    end
    chk("t3_starve", got, 1);
    a_req = 0; b_req = 1;
    repeat (2) nxt();
    reset_n = 0;
    @(negedge clk); chk("t4_acks", {a_ack, b_ack}, 0);
    nxt();
    @(negedge clk); chk("t4_we", mem_we, 0); chk("t4_busy", busy, 0);
    reset_n = 1; a_req = 1;
    @(negedge clk); chk("t4_first", {a_ack, b_ack}, 2'b10);
    nxt();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); aa = a_ack; bb = b_ack;
      nxt();
      if (aa || !a_req || $urandom_range(0, 15) == 0) begin
        a_req = $urandom_range(0, 3) != 0;
        a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (bb || !b_req || $urandom_range(0, 15) == 0) begin
        b_req = $urandom_range(0, 2) != 0;
        b_addr = AW'($urandom); b_data = DW'($urandom);
      end
      cnt_clr = $urandom_range(0, 63) == 0;
      if ($urandom_range(0, 499) == 0) reset_n = 0;
      else reset_n = 1;
    end
    reset_n = 1; cnt_clr = 0; a_req = 1; b_req = 1;
    repeat (65540) nxt();
    @(negedge clk); chk("t5_sat", conflict_cnt, 16'hFFFF);
    nxt();
    @(negedge clk); chk("t5_hold", conflict_cnt, 16'hFFFF);
    cnt_clr = 1;
    nxt(); cnt_clr = 0;
    @(negedge clk); chk("t5_clr", conflict_cnt, 0);
    nxt();
    en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_wr_arbiter.md
Name: pixel_wr_arbiter

Overview:
- Shares the single write port of the VGA pixel buffer between two writers.
  - Requester A: the Nios Avalon bridge.
  - Requester B: the custom processor's drawing datapath.
- Arbitration is round-robin with bounded bursts, so neither writer starves.
- Memory-side outputs are registered and feed the pixel buffer inside the VGA peripheral.
- A saturating contention counter is exposed for debug on the LED/HEX path.

Parameters:
- ADDR_W, 15, pixel address width (160x120 frame = 19200 pixels).
- DATA_W, 3, pixel colour width (1 bit each R/G/B).
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- a_req  in  1  requester A write request; held until acked.
- a_addr  in  ADDR_W  requester A pixel address.
- a_data  in  DATA_W  requester A pixel colour.
- a_ack  out  1  combinational; transfer happens on the edge where a_req&a_ack.
- b_req, b_addr, b_data, b_ack: same as A, for requester B.
- cnt_clr  in  1  synchronous clear of conflict_cnt.
- mem_we  out  1  registered write strobe to the pixel buffer.
- mem_addr  out  ADDR_W  registered write address.
- mem_data  out  DATA_W  registered write data.
- busy  out  1  registered; high while the arbiter owner state is not IDLE.
- conflict_cnt  out  16  saturating count of cycles with a_req&b_req both high.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, burst_cnt=0, last_served=B (so A wins the first tie).
  - mem_we=0, mem_addr=0, mem_data=0, busy=0, conflict_cnt=0.
  - a_ack=b_ack=0 while reset_n is low, regardless of req inputs.
- States:
  - IDLE: no owner.
  - OWN_A: A granted last cycle.
  - OWN_B: B granted last cycle.
  - burst_cnt (4 bits) counts consecutive grants to the current owner.
- Winner selection (combinational, from registered state and current reqs):
  - IDLE, single req: that requester wins.
  - IDLE, both req: the requester != last_served wins.
  - OWN_X, x_req and (burst_cnt<MAX_BURST or other not requesting): X wins again.
  - OWN_X, other requester requesting, and (x_req low or burst_cnt==MAX_BURST): other wins.
  - No req: no winner.
- Outputs of the selection:
  - a_ack = winner==A; b_ack = winner==B. At most one ack per cycle.
- Next state:
  - Winner W: state<=OWN_W, last_served<=W.
  - burst_cnt <= (W==current owner) ? burst_cnt+1 : 1.
  - burst_cnt saturates at MAX_BURST; that only happens with no contention, and it resets on owner change.
  - No winner: state<=IDLE, burst_cnt<=0. last_served is kept.
- Datapath:
  - On an edge with a winner: mem_we<=1; mem_addr/mem_data <= the winner's addr/data.
  - Otherwise mem_we<=0; mem_addr/mem_data hold their previous values.
  - Latency: write appears on the mem_* outputs 1 cycle after the acked edge.
  - Throughput: 1 write/cycle.
- Requester protocol:
  - Addr/data must be stable while req is high and not yet acked.
  - The requester may present the next write on the cycle after the ack edge.
  - Dropping req before ack cancels the request; nothing is written.
- busy <= (next state != IDLE).
- conflict_cnt:
  - cnt_clr has priority: clears to 0 even if contention occurs the same cycle.
  - Else increments when a_req&b_req, saturating at 16'hFFFF (no wrap).
- Reset mid-burst: an in-flight acked write already registered is discarded (mem_we forced 0). Requesters re-request after reset.

Decomposition:
- Shared package pixel_arb_pkg:
  - Owner-state enum {IDLE, OWN_A, OWN_B}.
  - Requester id constants REQ_A/REQ_B.
  - Default ADDR_W/DATA_W constants, shared with the VGA peripheral.
- One natural sub-module: sat_counter16 (clk, reset_n, clr, inc, q). Reused by other debug counters.

Test Plan:
- Single requester: A writes addr 0x0005 data 3'b101 for 1 cycle -> a_ack same cycle; next cycle mem_we=1, mem_addr=0x0005, mem_data=5; b_ack never high.
- First tie after reset: a_req=b_req=1 constantly -> A acked for 4 cycles, then B for 4, then A. mem_we high every cycle; conflict_cnt increments each cycle.
- No starvation: B holds req while A streams 20 writes -> B acked no later than A's 5th consecutive request cycle.
- Uncontended burst: A alone for 10 cycles -> 10 consecutive acks, no forced switch, conflict_cnt stays 0.
- Saturation and clear: preload via 65540 contention cycles -> conflict_cnt=0xFFFF and holds. cnt_clr together with contention -> 0 next cycle.
- Reset mid-burst: reset_n low during OWN_B with b_req high -> acks 0 and mem_we=0 during reset. After release with both requesting, A acked first.
